epochtv1_bus_master: RTL

Host-side initiator for the Epoch TV-1 CPU bus. Accepts byte read/write requests on a valid/ready interface, queues them in a small FIFO, and replays each one as a CE-aligned `CSB`/`RDB`/`WRB` bus cycle that the TV-1 responder can sample. Returns read data on a one-cycle response strobe. Sits between debug/save-state/loader logic and the TV-1 CPU bus, muxed with the real CPU's bus.

---
 rtl/epochtv1_bus_master.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/epochtv1_bus_master.sv
// epochtv1_bus_master
//
// Host-side initiator for the Epoch TV-1 CPU bus. Byte read/write requests are
// queued in a small FIFO. Each request is then replayed as a CE-aligned
// CSB/RDB/WRB bus cycle: SETUP, then STROBE for HOLD_CE pulses, then RECOVER.
// Read data is returned on a one-CLK response strobe.
//
// Optional feature macro: EPOCHTV1_BUS_ERRCHK_EN
//   When defined, requests to the unmapped range $1600-$1FFF are popped but
//   never issued on the bus. An unmapped read returns 8'hFF. Each dropped
//   request pulses the extra ERR output for one CLK.
//
// Ports:
//   CLK, RST         clock (XTAL*2), asynchronous active-high reset
//   CE               pixel clock enable shared with the TV-1
//   REQ_*            request channel (valid/ready, we, 13-bit addr, wdata)
//   RSP_VALID/RDATA  one-CLK read response pulse; data held until next response
//   BUSY             FIFO non-empty or an access in progress
//   A, DB_O, DB_OE   bus address, write data, data-bus output enable
//   DB_I             bus read data from the TV-1
//   RDB, WRB, CSB    active-low read strobe, write strobe, chip select
//   ERR              (EPOCHTV1_BUS_ERRCHK_EN only) dropped-request pulse

module epochtv1_bus_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HOLD_CE    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [12:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        BUSY,
    output logic [12:0] A,
    output logic [7:0]  DB_O,
    output logic        DB_OE,
    input  logic [7:0]  DB_I,
    output logic        RDB,
    output logic        WRB,
    output logic        CSB
`ifdef EPOCHTV1_BUS_ERRCHK_EN
    ,
    output logic        ERR
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(HOLD_CE) + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRecover} state_e;

    // Entry layout: {we, addr[12:0], wdata[7:0]}
    logic [21:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full, empty, push, pop;

    state_e           state_q, state_d;
    logic [21:0]      cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rsp_fire, drop;
    logic [7:0]       rsp_data;
    logic             csb_d, rdb_d, wrb_d, dboe_d;
    logic [12:0]      a_d;
    logic [7:0]       dbo_d;

    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign empty     = (occ == '0);
    assign push      = REQ_VALID && !full;
    assign REQ_READY = !full;
    assign BUSY      = !empty || (state_q != StIdle);

    // Storage is not reset; occupancy alone defines validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {REQ_WE, REQ_ADDR, REQ_WDATA};
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      occ <= occ + OCC_W'(1);
            else if (!push && pop) occ <= occ - OCC_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        drop     = 1'b0;
        rsp_fire = 1'b0;
        rsp_data = DB_I;
        if (CE) begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        pop   = 1'b1;
                        cmd_d = fifo_mem[rd_ptr];
`ifdef EPOCHTV1_BUS_ERRCHK_EN
                        if (fifo_mem[rd_ptr][20:17] >= 4'b1011) begin
                            drop     = 1'b1;
                            rsp_fire = !fifo_mem[rd_ptr][21];
                            rsp_data = 8'hFF;
                        end else begin
                            state_d = StSetup;
                        end
`else
                        state_d = StSetup;
`endif
                    end
                end
                StSetup: begin
                    state_d = StStrobe;
                    cnt_d   = CNT_W'(HOLD_CE - 1);
                end
                StStrobe: begin
                    if (cnt_q == '0) begin
                        rsp_fire = !cmd_q[21];
                        state_d  = StRecover;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StRecover: state_d = StIdle;
            endcase
        end

        // Bus pins are registered from the next state so they move on CE edges only.
        csb_d  = 1'b1;
        rdb_d  = 1'b1;
        wrb_d  = 1'b1;
        a_d    = '0;
        dbo_d  = '0;
        dboe_d = 1'b0;
        if (state_d == StSetup || state_d == StStrobe) begin
            csb_d = 1'b0;
            a_d   = cmd_d[20:8];
            if (cmd_d[21]) begin
                dbo_d  = cmd_d[7:0];
                dboe_d = 1'b1;
            end
            if (state_d == StStrobe) begin
                if (cmd_d[21]) wrb_d = 1'b0;
                else           rdb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            cnt_q     <= '0;
            CSB       <= 1'b1;
            RDB       <= 1'b1;
            WRB       <= 1'b1;
            A         <= '0;
            DB_O      <= '0;
            DB_OE     <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
`ifdef EPOCHTV1_BUS_ERRCHK_EN
            ERR       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            RSP_VALID <= rsp_fire;
            if (rsp_fire) RSP_RDATA <= rsp_data;
            if (CE) begin
                CSB   <= csb_d;
                RDB   <= rdb_d;
                WRB   <= wrb_d;
                A     <= a_d;
                DB_O  <= dbo_d;
                DB_OE <= dboe_d;
            end
`ifdef EPOCHTV1_BUS_ERRCHK_EN
            ERR <= drop;
`endif
        end
    end

`ifndef EPOCHTV1_BUS_ERRCHK_EN
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
